// File: rtl/display_scan_ctrl.sv
// ============================================================================
//  Module   : display_scan_ctrl
//  Purpose  : Time-multiplexed 7-segment scan controller with frame-aligned
//             value commit, inter-digit blanking and leading-zero blanking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int PRESC = 50000,
    parameter int GUARD = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   Valor,
    input  logic                Carrega,
    output logic                Pronto,
    input  logic                Supressao,
    output logic [3:0]          Entrada,
    output logic                Apagar,
    output logic [NDIG-1:0]     Digito,
    output logic                Quadro
);

    localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(PRESC - 1);
    localparam logic [CW-1:0] c_GUARD    = CW'(GUARD);
    localparam logic [IW-1:0] c_IDX_LAST = IW'(NDIG - 1);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt,     w_cnt_nxt;
    logic [IW-1:0]      r_idx,     w_idx_nxt;
    logic [4*NDIG-1:0]  r_active,  w_active_nxt;
    logic [4*NDIG-1:0]  r_pending, w_pending_nxt;
    logic               r_pend_v,  w_pend_v_nxt;

    logic               r_pronto,  w_pronto_nxt;
    logic [3:0]         r_entrada, w_entrada_nxt;
    logic               r_apagar,  w_apagar_nxt;
    logic [NDIG-1:0]    r_digito,  w_digito_nxt;
    logic               r_quadro,  w_quadro_nxt;

    logic               w_wrap;
    logic               w_boundary;
    logic               w_accept;
    logic               w_commit;
    logic [3:0]         w_nib [NDIG];
    logic [NDIG-1:0]    w_lz;
    logic               w_supp;
    logic               w_lit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_GUARD;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_active  <= '0;
            r_pending <= '0;
            r_pend_v  <= 1'b0;
            r_pronto  <= 1'b1;
            r_entrada <= 4'h0;
            r_apagar  <= 1'b1;
            r_digito  <= '1;
            r_quadro  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            r_pend_v  <= w_pend_v_nxt;
            r_pronto  <= w_pronto_nxt;
            r_entrada <= w_entrada_nxt;
            r_apagar  <= w_apagar_nxt;
            r_digito  <= w_digito_nxt;
            r_quadro  <= w_quadro_nxt;
        end
    end

    // Next-state: counters, slot FSM and the load/commit handshake.
    // Accept needs pend_v=0 and commit needs pend_v=1, so a load taken on the
    // boundary cycle naturally waits for the following boundary.
    always_comb begin
        w_wrap        = (r_cnt == c_CNT_LAST);
        w_boundary    = w_wrap && (r_idx == c_IDX_LAST);
        w_accept      = Carrega && r_pronto;
        w_commit      = w_boundary && r_pend_v;
        w_cnt_nxt     = w_wrap ? '0 : r_cnt + 1'b1;
        w_idx_nxt     = r_idx;
        w_state_nxt   = r_state;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_pend_v_nxt  = r_pend_v;

        if (w_wrap)
            w_idx_nxt = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;

        case (r_state)
            ST_GUARD: if (w_cnt_nxt == c_GUARD) w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_wrap)               w_state_nxt = ST_GUARD;
            default:                            w_state_nxt = ST_GUARD;
        endcase

        if (w_commit) begin
            w_active_nxt = r_pending;
            w_pend_v_nxt = 1'b0;
        end
        if (w_accept) begin
            w_pending_nxt = Valor;
            w_pend_v_nxt  = 1'b1;
        end
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_nib
        assign w_nib[i] = w_active_nxt[4*i +: 4];
    end

    // w_lz[i] = nibbles NDIG-1 down to i are all zero
    always_comb begin
        w_lz           = '0;
        w_lz[NDIG-1]   = (w_nib[NDIG-1] == 4'h0);
        for (int i = NDIG - 2; i >= 0; i--)
            w_lz[i] = w_lz[i+1] && (w_nib[i] == 4'h0);
    end

    // Outputs are computed from next-state so the registers line up with cnt/idx.
    always_comb begin
        w_supp        = Supressao && (w_idx_nxt != '0) && w_lz[w_idx_nxt];
        w_lit         = (w_state_nxt == ST_SHOW) && !w_supp;
        w_entrada_nxt = w_nib[w_idx_nxt];
        w_apagar_nxt  = !w_lit;
        w_digito_nxt  = '1;
        if (w_lit)
            w_digito_nxt[w_idx_nxt] = 1'b0;
        w_quadro_nxt  = (w_cnt_nxt == c_CNT_LAST) && (w_idx_nxt == c_IDX_LAST);
        w_pronto_nxt  = !w_pend_v_nxt;
    end

    assign Pronto  = r_pronto;
    assign Entrada = r_entrada;
    assign Apagar  = r_apagar;
    assign Digito  = r_digito;
    assign Quadro  = r_quadro;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
//  Module   : tb_display_scan_ctrl
//  Purpose  : Randomized and directed checking of display_scan_ctrl against a
//             cycle-count based reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int PRESC = 8;
    localparam int GUARD = 2;
    localparam int FRAME = NDIG * PRESC;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Valor;
    logic        Carrega;
    logic        Pronto;
    logic        Supressao;
    logic [3:0]  Entrada;
    logic        Apagar;
    logic [3:0]  Digito;
    logic        Quadro;

    display_scan_ctrl #(
        .NDIG  (NDIG),
        .PRESC (PRESC),
        .GUARD (GUARD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Valor     (Valor),
        .Carrega   (Carrega),
        .Pronto    (Pronto),
        .Supressao (Supressao),
        .Entrada   (Entrada),
        .Apagar    (Apagar),
        .Digito    (Digito),
        .Quadro    (Quadro)
    );

    always #5 clk = ~clk;

    // Reference model: position derived from elapsed cycles since reset
    int t;
    int m_act;
    int m_pend;
    bit m_pv;
    bit m_sup;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
    endtask

    task automatic step();
        int  pos, d, upper;
        bit  boundary, commit, accept, supp, lit;
        logic [3:0] exp_dig;
        @(posedge clk);
        if (reset) begin
            t      = 0;
            m_act  = 0;
            m_pend = 0;
            m_pv   = 1'b0;
        end else begin
            boundary = ((t % FRAME) == FRAME - 1);
            commit   = boundary && m_pv;
            accept   = Carrega && !m_pv;
            if (commit) begin
                m_act = m_pend;
                m_pv  = 1'b0;
            end
            if (accept) begin
                m_pend = int'(Valor);
                m_pv   = 1'b1;
            end
            t++;
        end
        m_sup = Supressao;
        #1;
        pos     = t % PRESC;
        d       = (t / PRESC) % NDIG;
        upper   = m_act >> (4 * d);
        supp    = m_sup && (d > 0) && (upper == 0);
        lit     = (pos >= GUARD) && !supp;
        exp_dig = lit ? ~(4'b0001 << d) : 4'hF;
        chk("Digito",  32'(Digito),  32'(exp_dig));
        chk("Apagar",  32'(Apagar),  32'(!lit));
        chk("Entrada", 32'(Entrada), 32'(upper & 15));
        chk("Quadro",  32'(Quadro),  32'((t % FRAME) == FRAME - 1));
        chk("Pronto",  32'(Pronto),  32'(!m_pv));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] v);
        Valor   = v;
        Carrega = 1'b1;
        step();
        Carrega = 1'b0;
    endtask

    task automatic align(input int target);
        int n = 0;
        while (((t % FRAME) != target) && (n < 2 * FRAME)) begin
            step();
            n++;
        end
        chk("align", 32'(t % FRAME), 32'(target));
    endtask

    initial begin
        reset     = 1'b1;
        Carrega   = 1'b0;
        Valor     = 16'h0;
        Supressao = 1'b0;
        t         = 0;
        m_act     = 0;
        m_pend    = 0;
        m_pv      = 1'b0;

        run(3);
        reset = 1'b0;
        run(40);

        // Load mid-frame, commit at boundary
        load(16'h12A4);
        run(70);

        Supressao = 1'b1;
        load(16'h0030);
        run(70);
        Supressao = 1'b0;
        run(40);
        Supressao = 1'b1;
        load(16'h0000);
        run(70);
        Supressao = 1'b0;

        // Second request while busy is dropped
        load(16'h1111);
        load(16'hFFFF);
        run(70);

        // Request on the boundary cycle
        align(FRAME - 1);
        load(16'h5555);
        run(80);

        // Reset during SHOW of digit 2 with a value pending
        align(2 * PRESC + 3);
        load(16'h9876);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(80);

        for (int i = 0; i < 2500; i++) begin
            reset   = ($urandom_range(0, 399) == 0);
            Carrega = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 4; k++)
                Valor[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0)
                Supressao = ~Supressao;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
